uart_tx_feeder: RTL and testbench

Buffered byte source that sits directly upstream of the UART TX model and drives its `start`/`data`/`busy` handshake. Producers (testbench scripts, debug monitors, CPU-side MMIO shim) push bytes through a valid/ready interface. The block queues them in a small FIFO and issues them to the UART one at a time. It never pulses `start` while a previous byte is in flight, and it accounts for the UART's registered start path before trusting `busy`.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/uart_tx_feeder.sv | 88 ++++++++
 tb/tb_uart_tx_feeder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit staging path.
//   uart_byte_t       : one UART payload byte
//   feeder_state_e    : issue FSM states of uart_tx_feeder
//   UART_GUARD_CYCLES : cycles busy is untrusted after a start pulse
package uart_pkg;
  typedef logic [7:0] uart_byte_t;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    DRAIN
  } feeder_state_e;

  localparam int UART_GUARD_CYCLES = 2;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset.
//   push/wr_data : write request; ignored while full (even with a same-cycle pop)
//   pop/rd_data  : rd_data is the head entry (combinational read); pop ignored while empty
//   full/empty   : decoded from the registered occupancy
//   level        : current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage carries no reset; only the pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_feeder.sv
// Buffered byte source driving the UART TX start/data/busy handshake.
//   in_valid/in_data/in_ready : producer push interface (in_ready = !full)
//   start                     : one-cycle issue pulse to the UART
//   data                      : byte to the UART, valid from the start cycle until the next start
//   busy                      : UART transmitter busy; untrusted for GUARD cycles after start
//   level                     : FIFO occupancy
//   sent_count                : bytes issued since reset, wraps at 2^16
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  parameter  int GUARD = UART_GUARD_CYCLES,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  uart_byte_t    in_data,
  output logic          in_ready,
  output logic          start,
  output uart_byte_t    data,
  input  logic          busy,
  output logic [LW-1:0] level,
  output logic [15:0]   sent_count
);
  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;

  feeder_state_e state, state_nxt;
  logic [GW-1:0] guard_cnt;
  uart_byte_t    head, data_q;
  logic [15:0]   sent_q;
  logic          fifo_full, fifo_empty, issue;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (in_valid),
    .wr_data (in_data),
    .pop     (issue),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign in_ready   = !fifo_full;
  assign start      = issue;
  // The head is driven straight out on the issue cycle so start and data
  // line up; the register then holds it until the next issue.
  assign data       = issue ? head : data_q;
  assign sent_count = sent_q;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        // rst gate keeps a stale queue entry from reaching the UART on the reset cycle
        if (!fifo_empty && !busy && !rst) begin
          issue     = 1'b1;
          state_nxt = HOLD;
        end
      end
      // busy is not looked at here: the UART has not registered the start yet
      HOLD:    if (guard_cnt == '0) state_nxt = DRAIN;
      DRAIN:   if (!busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      guard_cnt <= '0;
      data_q    <= '0;
      sent_q    <= '0;
    end else begin
      state <= state_nxt;
      if (issue) begin
        data_q    <= head;
        sent_q    <= sent_q + 1'b1;
        guard_cnt <= GW'(GUARD - 1);
      end else if (state == HOLD && guard_cnt != '0) begin
        guard_cnt <= guard_cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;
  localparam int FRAME = 40;   // UART frame length in clocks (10 bits x 4 clk)
  localparam int GUARD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        start;
  logic [7:0]  data;
  logic        busy;
  logic [4:0]  level;
  logic [15:0] sent_count;

  logic busy_force;
  logic model_en;
  int   mdl_cnt  = 0;
  int   cyc      = 0;
  int   last_st  = 0;
  bit   have_last = 0;
  int   proto_err = 0;
  logic [7:0] rx_q[$];
  int         st_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_feeder #(.DEPTH(16), .GUARD(GUARD)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .start      (start),
    .data       (data),
    .busy       (busy),
    .level      (level),
    .sent_count (sent_count)
  );

  // UART model: start is registered one cycle, busy rises the cycle after,
  // then stays high for FRAME cycles. Not reset by the feeder's rst.
  assign busy = busy_force || (model_en && mdl_cnt != 0 && mdl_cnt <= FRAME);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mdl_cnt != 0) mdl_cnt <= mdl_cnt - 1;
    if (start) begin
      rx_q.push_back(data);
      st_q.push_back(cyc);
      $display("uart model: tx 0x%02h at cycle %0d", data, cyc);
      if (busy) proto_err <= proto_err + 1;
      if (have_last && (cyc - last_st) < GUARD + 2) proto_err <= proto_err + 1;
      last_st   <= cyc;
      have_last <= 1'b1;
      if (model_en) mdl_cnt <= FRAME + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; busy_force = 1'b0; model_en = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL reset_start: got %0b want 0", start); end
    n_cmp++; if (data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %02h want 00", data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", level); end
    n_cmp++; if (sent_count !== 16'd0) begin n_bad++; $display("FAIL reset_sent: got %0d want 0", sent_count); end
    tick();
  endtask

  task automatic test_single();
    rx_q.delete();
    in_valid = 1'b1; in_data = 8'h55;
    #1;
    n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL single_no_bypass: got %0b want 0", start); end
    tick();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (start !== 1'b1) begin n_bad++; $display("FAIL single_start: got %0b want 1", start); end
    n_cmp++; if (data !== 8'h55) begin n_bad++; $display("FAIL single_data: got %02h want 55", data); end
    n_cmp++; if (level !== 5'd1) begin n_bad++; $display("FAIL single_level: got %0d want 1", level); end
    tick();
    n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL single_one_pulse: got %0b want 0", start); end
    n_cmp++; if (sent_count !== 16'd1) begin n_bad++; $display("FAIL single_sent: got %0d want 1", sent_count); end
    n_cmp++; if (data !== 8'h55) begin n_bad++; $display("FAIL single_data_hold: got %02h want 55", data); end
    repeat (FRAME + 10) tick();
    n_cmp++; if (rx_q.size() != 1 || rx_q[0] !== 8'h55)
      begin n_bad++; $display("FAIL single_rx: got %0d bytes want 1 byte 55", rx_q.size()); end
  endtask

  task automatic test_burst();
    int waited;
    rx_q.delete();
    busy_force = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'(i + 1);
      tick();
    end
    in_data = 8'h11;   // 17th offer, must be refused
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL burst_in_ready: got %0b want 0", in_ready); end
    n_cmp++; if (level !== 5'd16) begin n_bad++; $display("FAIL burst_level_full: got %0d want 16", level); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (level !== 5'd16) begin n_bad++; $display("FAIL burst_refused: got level %0d want 16", level); end
    busy_force = 1'b0;
    waited = 0;
    while (rx_q.size() < 16 && waited < 16 * (FRAME + 8)) begin tick(); waited++; end
    repeat (FRAME + 10) tick();
    n_cmp++; if (rx_q.size() != 16) begin n_bad++; $display("FAIL burst_count: got %0d want 16", rx_q.size()); end
    for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
      n_cmp++;
      if (rx_q[i] !== 8'(i + 1)) begin n_bad++; $display("FAIL burst_order[%0d]: got %02h want %02h", i, rx_q[i], 8'(i + 1)); end
    end
    n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL burst_empty: got %0d want 0", level); end
  endtask

  task automatic test_push_pop();
    rx_q.delete();
    busy_force = 1'b1;
    push_byte(8'h61);
    in_valid = 1'b1; in_data = 8'h62; busy_force = 1'b0;
    #1;
    n_cmp++; if (start !== 1'b1 || data !== 8'h61)
      begin n_bad++; $display("FAIL pp_start: got start %0b data %02h want 1 61", start, data); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (level !== 5'd1) begin n_bad++; $display("FAIL pp_level: got %0d want 1", level); end
    repeat (2 * FRAME + 20) tick();
    n_cmp++; if (rx_q.size() != 2 || rx_q[0] !== 8'h61 || rx_q[1] !== 8'h62)
      begin n_bad++; $display("FAIL pp_rx: got %0d bytes want 61 62", rx_q.size()); end
  endtask

  task automatic test_busy_stall();
    busy_force = 1'b1;
    push_byte(8'h77);
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL stall_cycle%0d: got start %0b want 0", i, start); end
      tick();
    end
    busy_force = 1'b0;
    #1;
    n_cmp++; if (start !== 1'b1 || data !== 8'h77)
      begin n_bad++; $display("FAIL stall_release: got start %0b data %02h want 1 77", start, data); end
    tick();
    repeat (FRAME + 10) tick();
  endtask

  task automatic test_guard_drain();
    model_en = 1'b0;
    // busy low through HOLD, high only in DRAIN
    busy_force = 1'b1;
    push_byte(8'h81);
    push_byte(8'h82);
    busy_force = 1'b0;
    #1;
    n_cmp++; if (start !== 1'b1 || data !== 8'h81)
      begin n_bad++; $display("FAIL guard_first: got start %0b data %02h want 1 81", start, data); end
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 3) busy_force = 1'b1;
      if (i == 5) busy_force = 1'b0;
      #1;
      n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL guard_s+%0d: got start %0b want 0", i, start); end
    end
    tick();
    n_cmp++; if (start !== 1'b1 || data !== 8'h82)
      begin n_bad++; $display("FAIL guard_second: got start %0b data %02h want 1 82", start, data); end
    tick();
    repeat (8) tick();
    // busy glitch inside HOLD is ignored; spacing is exactly GUARD+2
    busy_force = 1'b1;
    push_byte(8'h83);
    push_byte(8'h84);
    busy_force = 1'b0;
    #1;
    n_cmp++; if (start !== 1'b1 || data !== 8'h83)
      begin n_bad++; $display("FAIL glitch_first: got start %0b data %02h want 1 83", start, data); end
    tick(); busy_force = 1'b1; #1;
    n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL glitch_s+1: got start %0b want 0", start); end
    tick(); busy_force = 1'b0;
    n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL glitch_s+2: got start %0b want 0", start); end
    tick();
    n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL glitch_s+3: got start %0b want 0", start); end
    tick();
    n_cmp++; if (start !== 1'b1 || data !== 8'h84)
      begin n_bad++; $display("FAIL glitch_s+4: got start %0b data %02h want 1 84", start, data); end
    tick();
    repeat (8) tick();
    model_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int waited;
    rx_q.delete();
    st_q.delete();
    busy_force = 1'b1;
    push_byte(8'hA5);
    push_byte(8'hB1);
    push_byte(8'hB2);
    push_byte(8'hB3);
    busy_force = 1'b0;
    #1;
    n_cmp++; if (start !== 1'b1 || data !== 8'hA5)
      begin n_bad++; $display("FAIL rmid_start: got start %0b data %02h want 1 a5", start, data); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL rmid_level: got %0d want 0", level); end
    n_cmp++; if (sent_count !== 16'd0) begin n_bad++; $display("FAIL rmid_sent: got %0d want 0", sent_count); end
    n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL rmid_no_start: got %0b want 0", start); end
    push_byte(8'h3C);
    waited = 0;
    while (rx_q.size() < 2 && waited < FRAME + 20) begin tick(); waited++; end
    n_cmp++; if (rx_q.size() != 2) begin n_bad++; $display("FAIL rmid_timeout: got %0d bytes want 2", rx_q.size()); end
    else begin
      n_cmp++; if (rx_q[1] !== 8'h3C) begin n_bad++; $display("FAIL rmid_next: got %02h want 3c", rx_q[1]); end
      n_cmp++; if (st_q[1] - st_q[0] != FRAME + 2)
        begin n_bad++; $display("FAIL rmid_spacing: got %0d want %0d", st_q[1] - st_q[0], FRAME + 2); end
    end
    tick();
    n_cmp++; if (sent_count !== 16'd1) begin n_bad++; $display("FAIL rmid_sent_after: got %0d want 1", sent_count); end
    repeat (FRAME + 10) tick();
  endtask

  task automatic test_wrap();
    force dut.sent_q = 16'hFFFF;
    tick();
    release dut.sent_q;
    #1;
    n_cmp++; if (sent_count !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_preload: got %04h want ffff", sent_count); end
    push_byte(8'h99);
    n_cmp++; if (start !== 1'b1) begin n_bad++; $display("FAIL wrap_start: got %0b want 1", start); end
    tick();
    n_cmp++; if (sent_count !== 16'h0000) begin n_bad++; $display("FAIL wrap_count: got %04h want 0000", sent_count); end
    repeat (FRAME + 10) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_push_pop();
    test_busy_stall();
    test_guard_drain();
    test_reset_mid();
    test_wrap();
    n_cmp++; if (proto_err != 0) begin n_bad++; $display("FAIL protocol: got %0d violations want 0", proto_err); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
